mem_port2_arbiter: RTL and testbench
====================================

Name: mem_port2_arbiter

Overview:
- Shares the second (non-CPU) port of the dual-port execution memory between two requesters.
- Requester 0 is the VGA scan-out fetcher: read-only, high priority.
- Requester 1 is a general read/write client (loader/DMA/debug).
- Provides req/gnt handshakes, a burst lock, starvation protection for requester 1, and return of read data with a valid strobe.

Parameters:
AW, 16, address width of memory port 2
DW, 16, data width of memory port 2
STARVE_LIMIT, 8, consecutive denied cycles of m1 after which m1 wins arbitration in IDLE
LOCK_MAX, 64, maximum consecutive cycles any requester may stay in a lock state

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  VGA read request
m0_addr  in  AW  VGA read address
m0_lock  in  1  VGA requests burst ownership
m0_gnt  out  1  VGA request accepted this cycle
m0_rvalid  out  1  m0_rdata valid
m0_rdata  out  DW  VGA read data
m1_req  in  1  client request
m1_we  in  1  client write enable (1 = write)
m1_addr  in  AW  client address
m1_wdata  in  DW  client write data
m1_lock  in  1  client requests burst ownership
m1_gnt  out  1  client request accepted this cycle
m1_rvalid  out  1  m1_rdata valid (reads only)
m1_rdata  out  DW  client read data
mem_addr  out  AW  to memory port 2 address
mem_wdata  out  DW  to memory port 2 write data
mem_we  out  1  to memory port 2 write enable
mem_rdata  in  DW  from memory port 2, one-cycle synchronous read latency
owner  out  2  current state encoding: 0 IDLE, 1 LOCK0, 2 LOCK1
stat_gnt0  out  16  grant counter for m0 (optional feature)
stat_gnt1  out  16  grant counter for m1 (optional feature)

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following:
  - State goes to IDLE.
  - Starvation counter, lock timer, both rvalid, both rdata, stat counters and owner all go to 0.
  - While reset is asserted, gnt outputs and mem_we are 0 and mem_addr/mem_wdata are 0.
- Grants are combinational from req and registered state. At most one gnt is high per cycle.
- Memory signals are combinational from the winner:
  - m0 winner: mem_addr=m0_addr, mem_we=0.
  - m1 winner: mem_addr=m1_addr, mem_we=m1_we, mem_wdata=m1_wdata.
  - No grant: mem_we=0, mem_addr holds the last granted address.
- Memory samples on the edge ending the grant cycle.
- Read return:
  - A registered tag records {winner, read}.
  - One cycle after a read grant, the winner's rvalid=1 for exactly one cycle and its rdata=mem_rdata.
  - rdata holds its value until the next read completes.
  - Writes never raise rvalid.
- Throughput: one grant per cycle; back-to-back grants are allowed, including alternating owners.
- IDLE:
  - If m1_req and starve_cnt==STARVE_LIMIT, grant m1.
  - Otherwise, if m0_req, grant m0.
  - Otherwise, if m1_req, grant m1.
  - If the granted requester has lock=1, go to LOCKx and clear the lock timer.
- LOCKx:
  - Only x may be granted (when x req=1); the other requester waits.
  - Lock timer increments every cycle.
  - Return to IDLE after any cycle in which x's lock=0, or in which the lock timer reaches LOCK_MAX-1 (forced release).
  - The first IDLE cycle after a forced release arbitrates normally. A still-asserted lock may re-lock only if x wins again.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle with m1_req=1 and m1_gnt=0.
  - Clears on m1_gnt, or when m1_req=0.
- Simultaneous events:
  - In IDLE, m0 and m1 both requesting with counter below limit: m0 wins.
  - m1 write granted while an m0 read return is pending: legal, since the tag is per cycle.
- Reset mid-burst: lock is abandoned and any pending rvalid is suppressed.
- Address/data widths pass straight through; no arithmetic except the counters, which saturate (starvation, lock) or wrap (stats).

Optional Feature:
- Macro: MEM_PORT2_ARB_STATS_EN.
- Defined: stat_gnt0/stat_gnt1 are 16-bit wrapping counters, incremented on each m0_gnt/m1_gnt respectively, and cleared by reset.
- Undefined: both outputs are tied to 0 and no counter registers are built.

Test Plan:
- Reset then m0_req=1 with m0_addr=0x0010 (memory holds 0xBEEF) -> m0_gnt=1 in the same cycle; next cycle m0_rvalid=1 and m0_rdata=0xBEEF; owner=0.
- m1_req=1, m1_we=1, m1_addr=0x0020, m1_wdata=0x1234 for one cycle, then m1 read of 0x0020 -> m1_gnt each cycle; mem_we=1 only on the first; m1_rvalid=1 with 0x1234 after the read; no rvalid for the write.
- m0_req and m1_req both held high continuously, with STARVE_LIMIT=8 and no locks -> m0 granted 8 cycles, m1 granted on the 9th, pattern repeats; never both gnt high.
- m1_lock=1 granted from IDLE, then m0_req asserted -> owner=2; m0_gnt=0 until m1_lock drops; with LOCK_MAX=64 and lock held, forced IDLE after 64 cycles and m0 wins the next arbitration.
- Assert reset=0 mid-lock, one cycle after an m0 read grant -> owner=0 immediately; m0_rvalid stays 0; stat counters are 0 (with MEM_PORT2_ARB_STATS_EN); after release, normal grants resume.
- With MEM_PORT2_ARB_STATS_EN: 65540 m0 grants -> stat_gnt0=4 (wrap). Without the macro: stat_gnt0=0 throughout.

Source files
------------

// File: rtl/mem_port2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port2_arbiter
//  Purpose  : Shares port 2 of the dual-port execution memory between the
//             VGA scan-out fetcher (m0, read-only, high priority) and a
//             general read/write client (m1). Provides combinational
//             req/gnt, burst locking with a forced-release timer, m1
//             starvation protection and one-cycle read-data return.
//  Options  : MEM_PORT2_ARB_STATS_EN - builds 16-bit wrapping grant counters
//             on stat_gnt0/stat_gnt1; otherwise both outputs are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port2_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 64
) (
    input  logic          clk,
    input  logic          reset,
    // requester 0 : VGA scan-out, read only
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    // requester 1 : general read/write client
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    // memory port 2
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    // status
    output logic [1:0]    owner,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1
);

    // ------------------------------------------------------------------------
    // Counter widths. Both counters stop at a known terminal value, so the
    // widths only need to hold that value (minimum one bit).
    // ------------------------------------------------------------------------
    localparam int c_SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int c_LW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
    localparam logic [c_LW-1:0] c_LOCK_LAST  = c_LW'(LOCK_MAX - 1);

    // Ownership state; the encoding is exported unchanged on 'owner'.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [c_SW-1:0] r_starveCnt;
    logic [c_SW-1:0] w_starveNext;
    logic [c_LW-1:0] r_lockTimer;
    logic [c_LW-1:0] w_lockTimerNext;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_m1Starved;
    logic            w_readGnt;

    // Last granted address/write data, so the memory port is quiet between
    // grants instead of following whatever the requesters happen to drive.
    logic [AW-1:0]   r_lastAddr;
    logic [DW-1:0]   r_lastWdata;

    // Read-return tag: a read was granted last cycle, and by whom.
    logic            r_tagRead;
    logic            r_tagWho;

    logic            w_rvalid0;
    logic            w_rvalid1;
    logic [DW-1:0]   r_held0;
    logic [DW-1:0]   r_held1;

    assign w_m1Starved = (r_starveCnt == c_STARVE_MAX);

    // Arbitration: pick at most one winner from the requests and the current
    // ownership. Everything is held off while reset is asserted.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (reset) begin
            case (r_state)
                ST_LOCK0: w_gnt0 = m0_req;
                ST_LOCK1: w_gnt1 = m1_req;
                default: begin
                    if (m1_req && w_m1Starved) begin
                        w_gnt1 = 1'b1;
                    end else if (m0_req) begin
                        w_gnt0 = 1'b1;
                    end else if (m1_req) begin
                        w_gnt1 = 1'b1;
                    end
                end
            endcase
        end
    end

    // Ownership transitions and lock timer: enter a lock when the winner
    // asks for it, leave when the owner drops lock or the timer runs out.
    always_comb begin
        w_stateNext     = r_state;
        w_lockTimerNext = r_lockTimer;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt0 && m0_lock) begin
                    w_stateNext     = ST_LOCK0;
                    w_lockTimerNext = '0;
                end else if (w_gnt1 && m1_lock) begin
                    w_stateNext     = ST_LOCK1;
                    w_lockTimerNext = '0;
                end
            end
            ST_LOCK0: begin
                if (!m0_lock || (r_lockTimer == c_LOCK_LAST)) begin
                    w_stateNext     = ST_IDLE;
                    w_lockTimerNext = '0;
                end else begin
                    w_lockTimerNext = r_lockTimer + 1'b1;
                end
            end
            ST_LOCK1: begin
                if (!m1_lock || (r_lockTimer == c_LOCK_LAST)) begin
                    w_stateNext     = ST_IDLE;
                    w_lockTimerNext = '0;
                end else begin
                    w_lockTimerNext = r_lockTimer + 1'b1;
                end
            end
            default: begin
                w_stateNext     = ST_IDLE;
                w_lockTimerNext = '0;
            end
        endcase
    end

    // Starvation counter: counts consecutive denied m1 requests, saturating.
    always_comb begin
        w_starveNext = r_starveCnt;
        if (!m1_req || w_gnt1) begin
            w_starveNext = '0;
        end else if (!w_m1Starved) begin
            w_starveNext = r_starveCnt + 1'b1;
        end
    end

    // Memory port is driven straight from the winner of this cycle.
    assign w_readGnt = w_gnt0 | (w_gnt1 & ~m1_we);
    assign mem_addr  = w_gnt0 ? m0_addr : (w_gnt1 ? m1_addr : r_lastAddr);
    assign mem_wdata = w_gnt1 ? m1_wdata : r_lastWdata;
    assign mem_we    = w_gnt1 & m1_we;

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign owner     = r_state;

    // Control registers: ownership, counters, held memory port values and
    // the read-return tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_starveCnt <= '0;
            r_lockTimer <= '0;
            r_lastAddr  <= '0;
            r_lastWdata <= '0;
            r_tagRead   <= 1'b0;
            r_tagWho    <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_starveCnt <= w_starveNext;
            r_lockTimer <= w_lockTimerNext;
            if (w_gnt0) begin
                r_lastAddr <= m0_addr;
            end else if (w_gnt1) begin
                r_lastAddr <= m1_addr;
            end
            if (w_gnt1) begin
                r_lastWdata <= m1_wdata;
            end
            r_tagRead <= w_readGnt;
            r_tagWho  <= w_gnt1;
        end
    end

    // The memory answers one cycle after the grant, so rvalid comes from the
    // tag and rdata passes mem_rdata through in that cycle, then holds it.
    assign w_rvalid0 = reset & r_tagRead & ~r_tagWho;
    assign w_rvalid1 = reset & r_tagRead &  r_tagWho;

    assign m0_rvalid = w_rvalid0;
    assign m1_rvalid = w_rvalid1;
    assign m0_rdata  = w_rvalid0 ? mem_rdata : r_held0;
    assign m1_rdata  = w_rvalid1 ? mem_rdata : r_held1;

    // Capture returned read data so each requester keeps its last result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_held0 <= '0;
            r_held1 <= '0;
        end else begin
            if (w_rvalid0) begin
                r_held0 <= mem_rdata;
            end
            if (w_rvalid1) begin
                r_held1 <= mem_rdata;
            end
        end
    end

`ifdef MEM_PORT2_ARB_STATS_EN
    logic [15:0] r_statGnt0;
    logic [15:0] r_statGnt1;

    // Grant statistics: free-running wrapping counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_statGnt0 <= '0;
            r_statGnt1 <= '0;
        end else begin
            r_statGnt0 <= r_statGnt0 + 16'(w_gnt0);
            r_statGnt1 <= r_statGnt1 + 16'(w_gnt1);
        end
    end

    assign stat_gnt0 = r_statGnt0;
    assign stat_gnt1 = r_statGnt1;
`else
    assign stat_gnt0 = 16'd0;
    assign stat_gnt1 = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port2_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port2_arbiter
//  Purpose  : Self-checking bench for mem_port2_arbiter. A cycle-level
//             transaction model predicts every output each cycle; directed
//             sequences pin the model with literal expectations, then
//             randomized traffic runs against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port2_arbiter;

    localparam int AW           = 16;
    localparam int DW           = 16;
    localparam int STARVE_LIMIT = 8;
    localparam int LOCK_MAX     = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_lock, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;
    logic [1:0]    owner;
    logic [15:0]   stat_gnt0, stat_gnt1;

    always #5 clk = ~clk;

    mem_port2_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_lock(m0_lock),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .owner(owner), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1)
    );

    // Memory attached to port 2: synchronous write, one-cycle read latency.
    logic [DW-1:0] envMem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) envMem[i] <= 16'((i * 7) ^ 32'h5A3C);
        envMem[16'h0010] <= 16'hBEEF;
    end
    always @(posedge clk) begin
        if (mem_we) envMem[mem_addr] <= mem_wdata;
        mem_rdata <= envMem[mem_addr];
    end

    // ------------------------------------------------------------------------
    // Reference model state (transaction level)
    // ------------------------------------------------------------------------
    logic [DW-1:0] refMem [0:65535];
    int            mOwner;        // 0 none, 1 m0 holds burst, 2 m1 holds burst
    int            mWaited;       // consecutive cycles m1 has been refused
    int            mLockCycles;   // cycles spent inside the current burst
    int            mPendWho;      // -1 none, else who gets data this cycle
    logic [DW-1:0] mPendData;
    logic [DW-1:0] mHeld0, mHeld1;
    logic [AW-1:0] mLastAddr;
    int            mStat0, mStat1;

    int nChecks = 0;
    int nErrors = 0;

    // Values observed in the most recent cycle, for literal checks.
    logic          lastGnt0, lastGnt1, lastMemWe, lastRvalid0, lastRvalid1;
    logic [DW-1:0] lastRdata0, lastRdata1;
    logic [AW-1:0] lastMemAddr;
    logic [1:0]    lastOwner;
    logic [15:0]   lastStat0, lastStat1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mOwner      = 0;
        mWaited     = 0;
        mLockCycles = 0;
        mPendWho    = -1;
        mPendData   = '0;
        mHeld0      = '0;
        mHeld1      = '0;
        mLastAddr   = '0;
        mStat0      = 0;
        mStat1      = 0;
    endtask

    // One clock cycle: apply inputs, compare every output to the model,
    // advance the model, then move to just after the next rising edge.
    task automatic doCycle(input logic rst,
                           input logic m0r, input logic [AW-1:0] a0, input logic l0,
                           input logic m1r, input logic we, input logic [AW-1:0] a1,
                           input logic [DW-1:0] wd, input logic l1);
        int      w;
        logic [AW-1:0] eAddr;
        logic    keep;
        reset = rst;
        m0_req = m0r; m0_addr = a0; m0_lock = l0;
        m1_req = m1r; m1_we = we; m1_addr = a1; m1_wdata = wd; m1_lock = l1;
        #3;
        if (!rst) begin
            modelReset();
            check("rst_gnt0",   32'(m0_gnt),    32'd0);
            check("rst_gnt1",   32'(m1_gnt),    32'd0);
            check("rst_we",     32'(mem_we),    32'd0);
            check("rst_addr",   32'(mem_addr),  32'd0);
            check("rst_wdata",  32'(mem_wdata), 32'd0);
            check("rst_rv0",    32'(m0_rvalid), 32'd0);
            check("rst_rv1",    32'(m1_rvalid), 32'd0);
            check("rst_rd0",    32'(m0_rdata),  32'd0);
            check("rst_rd1",    32'(m1_rdata),  32'd0);
            check("rst_owner",  32'(owner),     32'd0);
            check("rst_stat0",  32'(stat_gnt0), 32'd0);
            check("rst_stat1",  32'(stat_gnt1), 32'd0);
        end else begin
            // Who wins this cycle
            if (mOwner == 1)      w = m0r ? 0 : -1;
            else if (mOwner == 2) w = m1r ? 1 : -1;
            else if (m1r && mWaited >= STARVE_LIMIT) w = 1;
            else if (m0r)         w = 0;
            else if (m1r)         w = 1;
            else                  w = -1;
            eAddr = (w == 0) ? a0 : (w == 1) ? a1 : mLastAddr;

            check("gnt0",  32'(m0_gnt),    32'(w == 0));
            check("gnt1",  32'(m1_gnt),    32'(w == 1));
            check("addr",  32'(mem_addr),  32'(eAddr));
            check("we",    32'(mem_we),    32'(w == 1 && we));
            if (w == 1) check("wdata", 32'(mem_wdata), 32'(wd));
            check("rv0",   32'(m0_rvalid), 32'(mPendWho == 0));
            check("rv1",   32'(m1_rvalid), 32'(mPendWho == 1));
            check("rd0",   32'(m0_rdata),  32'((mPendWho == 0) ? mPendData : mHeld0));
            check("rd1",   32'(m1_rdata),  32'((mPendWho == 1) ? mPendData : mHeld1));
            check("owner", 32'(owner),     32'(mOwner));
            check("stat0", 32'(stat_gnt0), 32'(mStat0));
            check("stat1", 32'(stat_gnt1), 32'(mStat1));

            // Read completion, then the new transaction
            if (mPendWho == 0) mHeld0 = mPendData;
            if (mPendWho == 1) mHeld1 = mPendData;
            mPendWho = -1;
            if (w == 0) begin
                mLastAddr = a0;
                mPendWho  = 0;
                mPendData = refMem[a0];
            end else if (w == 1) begin
                mLastAddr = a1;
                if (we) refMem[a1] = wd;
                else begin
                    mPendWho  = 1;
                    mPendData = refMem[a1];
                end
            end
`ifdef MEM_PORT2_ARB_STATS_EN
            if (w == 0) mStat0 = (mStat0 + 1) % 65536;
            if (w == 1) mStat1 = (mStat1 + 1) % 65536;
`endif
            // Starvation bookkeeping
            if (m1r && w != 1) mWaited = (mWaited + 1 > STARVE_LIMIT) ? STARVE_LIMIT : mWaited + 1;
            else               mWaited = 0;
            // Burst ownership
            if (mOwner == 0) begin
                if (w == 0 && l0)      begin mOwner = 1; mLockCycles = 0; end
                else if (w == 1 && l1) begin mOwner = 2; mLockCycles = 0; end
            end else begin
                mLockCycles++;
                keep = (mOwner == 1) ? l0 : l1;
                if (!keep || mLockCycles >= LOCK_MAX) mOwner = 0;
            end
        end
        lastGnt0 = m0_gnt;   lastGnt1 = m1_gnt;   lastMemWe = mem_we;
        lastMemAddr = mem_addr;
        lastRvalid0 = m0_rvalid; lastRvalid1 = m1_rvalid;
        lastRdata0 = m0_rdata;   lastRdata1 = m1_rdata;
        lastOwner = owner;   lastStat0 = stat_gnt0; lastStat1 = stat_gnt1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        doCycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Run-time bound
    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int m1First, m1Second, m1Count, lockCount, gntAfter, seenIdle;
        int burst0, burst1;
        logic r, q0, q1, wr, k0, k1;
        reset = 1'b0;
        m0_req = 0; m0_addr = '0; m0_lock = 0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
        for (int i = 0; i < 65536; i++) refMem[i] = 16'((i * 7) ^ 32'h5A3C);
        refMem[16'h0010] = 16'hBEEF;
        modelReset();
        @(posedge clk);
        #1;

        // Reset state
        doCycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        doCycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0020, '0, 1'b0);
        check("reset_owner", 32'(lastOwner), 32'd0);
        check("reset_gnt0",  32'(lastGnt0),  32'd0);

        // m0 read of 0x0010
        doCycle(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("m0_gnt_same_cycle", 32'(lastGnt0), 32'd1);
        check("m0_mem_addr", 32'(lastMemAddr), 32'h0010);
        idle();
        check("m0_rvalid", 32'(lastRvalid0), 32'd1);
        check("m0_rdata",  32'(lastRdata0),  32'hBEEF);
        check("m0_owner",  32'(lastOwner),   32'd0);
        idle();
        check("m0_rvalid_pulse", 32'(lastRvalid0), 32'd0);
        check("m0_rdata_hold",   32'(lastRdata0),  32'hBEEF);

        // m1 write then read back
        doCycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0);
        check("m1_wr_gnt", 32'(lastGnt1),  32'd1);
        check("m1_wr_we",  32'(lastMemWe), 32'd1);
        doCycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
        check("m1_rd_gnt", 32'(lastGnt1),    32'd1);
        check("m1_rd_we",  32'(lastMemWe),   32'd0);
        check("m1_wr_no_rvalid", 32'(lastRvalid1), 32'd0);
        idle();
        check("m1_rvalid", 32'(lastRvalid1), 32'd1);
        check("m1_rdata",  32'(lastRdata1),  32'h1234);

        // Continuous contention: 8 m0 grants then one m1 grant, repeating
        m1First = -1; m1Second = -1; m1Count = 0;
        for (int k = 0; k < 18; k++) begin
            doCycle(1'b1, 1'b1, 16'(16'h0100 + k), 1'b0, 1'b1, 1'b0, 16'(16'h0200 + k), '0, 1'b0);
            check("contend_one_gnt", 32'(lastGnt0 ^ lastGnt1), 32'd1);
            if (lastGnt1) begin
                m1Count++;
                if (m1First < 0) m1First = k;
                else if (m1Second < 0) m1Second = k;
            end
        end
        check("contend_m1_count",  32'(m1Count),  32'd2);
        check("contend_m1_first",  32'(m1First),  32'd8);
        check("contend_m1_second", 32'(m1Second), 32'd17);
        idle();

        // m1 burst released by dropping lock
        doCycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h0030, '0, 1'b1);
        check("lock1_entry_gnt", 32'(lastGnt1), 32'd1);
        for (int k = 0; k < 3; k++) begin
            doCycle(1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0, 16'(16'h0031 + k), '0, 1'b1);
            check("lock1_owner", 32'(lastOwner), 32'd2);
            check("lock1_m0_blocked", 32'(lastGnt0), 32'd0);
        end
        doCycle(1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0034, '0, 1'b0);
        check("lock1_drop_owner", 32'(lastOwner), 32'd2);
        doCycle(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("lock1_after_owner", 32'(lastOwner), 32'd0);
        check("lock1_after_gnt0",  32'(lastGnt0),  32'd1);
        idle();

        // m1 burst held: forced release after LOCK_MAX cycles, m0 wins next
        doCycle(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 16'h0050, '0, 1'b1);
        lockCount = 0; gntAfter = 0; seenIdle = 0;
        for (int k = 0; k < LOCK_MAX + 2; k++) begin
            doCycle(1'b1, 1'b1, 16'h0060, 1'b0, 1'b1, 1'b0, 16'h0050, '0, 1'b1);
            if (lastOwner == 2'd2) lockCount++;
            else if (seenIdle == 0) begin
                seenIdle = 1;
                gntAfter = int'(lastGnt0);
            end
        end
        check("forced_lock_cycles", 32'(lockCount), 32'(LOCK_MAX));
        check("forced_m0_wins",     32'(gntAfter),  32'd1);
        idle();

        // Reset in the middle of an m0 burst, one cycle after a read grant
        doCycle(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        doCycle(1'b1, 1'b1, 16'h0011, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("midlock_owner", 32'(lastOwner), 32'd1);
        doCycle(1'b0, 1'b1, 16'h0012, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("midrst_owner",  32'(lastOwner),   32'd0);
        check("midrst_rvalid", 32'(lastRvalid0), 32'd0);
        check("midrst_stat0",  32'(lastStat0),   32'd0);
        doCycle(1'b1, 1'b1, 16'h0013, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("resume_gnt0", 32'(lastGnt0), 32'd1);
        idle();
        check("resume_rdata", 32'(lastRdata0), 32'(16'((19 * 7) ^ 32'h5A3C)));

        // Randomized traffic with occasional bursts and resets
        burst0 = 0; burst1 = 0;
        for (int k = 0; k < 4000; k++) begin
            r  = ($urandom_range(0, 599) != 0);
            q0 = ($urandom_range(0, 1) == 1);
            q1 = ($urandom_range(0, 9) < 6);
            wr = ($urandom_range(0, 1) == 1);
            if (burst0 == 0 && $urandom_range(0, 39) == 0) burst0 = int'($urandom_range(1, 80));
            if (burst1 == 0 && $urandom_range(0, 39) == 0) burst1 = int'($urandom_range(1, 80));
            k0 = (burst0 > 0);
            k1 = (burst1 > 0);
            if (burst0 > 0) burst0--;
            if (burst1 > 0) burst1--;
            doCycle(r, q0, 16'($urandom_range(0, 31)), k0,
                    q1, wr, 16'($urandom_range(0, 31)), 16'($urandom), k1);
        end
        idle();

`ifdef MEM_PORT2_ARB_STATS_EN
        doCycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 65540; k++) begin
            doCycle(1'b1, 1'b1, 16'(k), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        idle();
        check("stat0_wrap", 32'(lastStat0), 32'd4);
        check("stat1_zero", 32'(lastStat1), 32'd0);
`else
        check("stat0_tied", 32'(lastStat0), 32'd0);
        check("stat1_tied", 32'(lastStat1), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
